// File: rtl/memory_bus_arbiter.sv
// Two-requester memory bus arbiter with a registered request stage and a tag FIFO routing read returns.
// Define MEMORY_BUS_ARBITER_RR_EN for round-robin arbitration; otherwise M0 has fixed priority.
module memory_bus_arbiter #(
  parameter int P_TAG_DEPTH   = 4,
  parameter int P_TAG_DEPTH_N = 2
) (
  input  logic        iCLOCK,
  input  logic        inRESET,
  input  logic        iM0_REQ,
  output logic        oM0_LOCK,
  input  logic [1:0]  iM0_ORDER,
  input  logic [3:0]  iM0_MASK,
  input  logic        iM0_RW,
  input  logic [31:0] iM0_ADDR,
  input  logic [31:0] iM0_DATA,
  output logic        oM0_VALID,
  input  logic        iM0_BUSY,
  output logic [63:0] oM0_DATA,
  input  logic        iM1_REQ,
  output logic        oM1_LOCK,
  input  logic [1:0]  iM1_ORDER,
  input  logic [3:0]  iM1_MASK,
  input  logic        iM1_RW,
  input  logic [31:0] iM1_ADDR,
  input  logic [31:0] iM1_DATA,
  output logic        oM1_VALID,
  input  logic        iM1_BUSY,
  output logic [63:0] oM1_DATA,
  output logic        oMEMORY_REQ,
  output logic [1:0]  oMEMORY_ORDER,
  output logic [3:0]  oMEMORY_MASK,
  output logic        oMEMORY_RW,
  output logic [31:0] oMEMORY_ADDR,
  output logic [31:0] oMEMORY_DATA,
  input  logic        iMEMORY_LOCK,
  input  logic        iMEMORY_VALID,
  input  logic [63:0] iMEMORY_DATA,
  output logic        oMEMORY_BUSY,
  output logic        oERR
);

  localparam int PTR_W = P_TAG_DEPTH_N;
  localparam int CNT_W = P_TAG_DEPTH_N + 1;

  logic             stageReq_q, stageReq_d;
  logic [1:0]       stageOrder_q, stageOrder_d;
  logic [3:0]       stageMask_q, stageMask_d;
  logic             stageRw_q, stageRw_d;
  logic [31:0]      stageAddr_q, stageAddr_d;
  logic [31:0]      stageData_q, stageData_d;
  logic             tagMem_q [P_TAG_DEPTH];
  logic [PTR_W-1:0] wrPtr_q, wrPtr_d, rdPtr_q, rdPtr_d;
  logic [CNT_W-1:0] tagCount_q, tagCount_d;
  logic             err_q, err_d;

  logic stageFree, fifoEmpty, fifoFull, m0Ok, m1Ok, grant0, grant1;
  logic push, pop, headId;

  // Full is judged on the registered count, so a pop in the same cycle never frees a slot.
  assign stageFree = !stageReq_q || !iMEMORY_LOCK;
  assign fifoEmpty = (tagCount_q == '0);
  assign fifoFull  = (tagCount_q == CNT_W'(P_TAG_DEPTH));
  assign m0Ok      = inRESET && iM0_REQ && stageFree && (iM0_RW || !fifoFull);
  assign m1Ok      = inRESET && iM1_REQ && stageFree && (iM1_RW || !fifoFull);

`ifdef MEMORY_BUS_ARBITER_RR_EN
  logic rrPtr_q, rrPtr_d;

  always_comb begin
    grant0  = m0Ok && (!m1Ok || !rrPtr_q);
    grant1  = m1Ok && (!m0Ok || rrPtr_q);
    rrPtr_d = rrPtr_q;
    if (m0Ok && m1Ok) rrPtr_d = ~rrPtr_q;
  end

  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) rrPtr_q <= 1'b0;
    else          rrPtr_q <= rrPtr_d;
  end
`else
  always_comb begin
    grant0 = m0Ok;
    grant1 = m1Ok && !m0Ok;
  end
`endif

  assign headId = tagMem_q[rdPtr_q];
  assign push   = (grant0 && !iM0_RW) || (grant1 && !iM1_RW);
  assign pop    = iMEMORY_VALID && !fifoEmpty;

  always_comb begin
    stageReq_d   = stageReq_q;
    stageOrder_d = stageOrder_q;
    stageMask_d  = stageMask_q;
    stageRw_d    = stageRw_q;
    stageAddr_d  = stageAddr_q;
    stageData_d  = stageData_q;
    wrPtr_d      = wrPtr_q;
    rdPtr_d      = rdPtr_q;
    tagCount_d   = tagCount_q;
    err_d        = err_q || (iMEMORY_VALID && fifoEmpty);
    if (grant0 || grant1) begin
      stageReq_d   = 1'b1;
      stageOrder_d = grant1 ? iM1_ORDER : iM0_ORDER;
      stageMask_d  = grant1 ? iM1_MASK  : iM0_MASK;
      stageRw_d    = grant1 ? iM1_RW    : iM0_RW;
      stageAddr_d  = grant1 ? iM1_ADDR  : iM0_ADDR;
      stageData_d  = grant1 ? iM1_DATA  : iM0_DATA;
    end else if (stageReq_q && !iMEMORY_LOCK) begin
      stageReq_d = 1'b0;
    end
    if (push) wrPtr_d = wrPtr_q + PTR_W'(1);
    if (pop)  rdPtr_d = rdPtr_q + PTR_W'(1);
    if (push && !pop)      tagCount_d = tagCount_q + CNT_W'(1);
    else if (!push && pop) tagCount_d = tagCount_q - CNT_W'(1);
  end

  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      stageReq_q   <= 1'b0;
      stageOrder_q <= '0;
      stageMask_q  <= '0;
      stageRw_q    <= 1'b0;
      stageAddr_q  <= '0;
      stageData_q  <= '0;
      wrPtr_q      <= '0;
      rdPtr_q      <= '0;
      tagCount_q   <= '0;
      err_q        <= 1'b0;
      for (int i = 0; i < P_TAG_DEPTH; i++) tagMem_q[i] <= 1'b0;
    end else begin
      stageReq_q   <= stageReq_d;
      stageOrder_q <= stageOrder_d;
      stageMask_q  <= stageMask_d;
      stageRw_q    <= stageRw_d;
      stageAddr_q  <= stageAddr_d;
      stageData_q  <= stageData_d;
      wrPtr_q      <= wrPtr_d;
      rdPtr_q      <= rdPtr_d;
      tagCount_q   <= tagCount_d;
      err_q        <= err_d;
      if (push) tagMem_q[wrPtr_q] <= grant1;
    end
  end

  assign oM0_LOCK      = !grant0;
  assign oM1_LOCK      = !grant1;
  assign oM0_VALID     = pop && !headId;
  assign oM1_VALID     = pop && headId;
  assign oM0_DATA      = oM0_VALID ? iMEMORY_DATA : 64'h0;
  assign oM1_DATA      = oM1_VALID ? iMEMORY_DATA : 64'h0;
  assign oMEMORY_BUSY  = !fifoEmpty && (headId ? iM1_BUSY : iM0_BUSY);
  assign oMEMORY_REQ   = stageReq_q;
  assign oMEMORY_ORDER = stageOrder_q;
  assign oMEMORY_MASK  = stageMask_q;
  assign oMEMORY_RW    = stageRw_q;
  assign oMEMORY_ADDR  = stageAddr_q;
  assign oMEMORY_DATA  = stageData_q;
  assign oERR          = err_q;

endmodule

// File: tb/tb_memory_bus_arbiter.sv
// Directed self-checking bench for memory_bus_arbiter; expectations follow MEMORY_BUS_ARBITER_RR_EN.
module tb_memory_bus_arbiter;

`ifdef MEMORY_BUS_ARBITER_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        iCLOCK = 1'b0;
  logic        inRESET;
  logic        iM0_REQ, iM0_RW, iM0_BUSY, oM0_LOCK, oM0_VALID;
  logic [1:0]  iM0_ORDER;
  logic [3:0]  iM0_MASK;
  logic [31:0] iM0_ADDR, iM0_DATA;
  logic [63:0] oM0_DATA;
  logic        iM1_REQ, iM1_RW, iM1_BUSY, oM1_LOCK, oM1_VALID;
  logic [1:0]  iM1_ORDER;
  logic [3:0]  iM1_MASK;
  logic [31:0] iM1_ADDR, iM1_DATA;
  logic [63:0] oM1_DATA;
  logic        oMEMORY_REQ, oMEMORY_RW, iMEMORY_LOCK, iMEMORY_VALID, oMEMORY_BUSY, oERR;
  logic [1:0]  oMEMORY_ORDER;
  logic [3:0]  oMEMORY_MASK;
  logic [31:0] oMEMORY_ADDR, oMEMORY_DATA;
  logic [63:0] iMEMORY_DATA;

  int checkCount = 0;
  int passCount  = 0;

  memory_bus_arbiter #(.P_TAG_DEPTH(4), .P_TAG_DEPTH_N(2)) dut (
    .iCLOCK(iCLOCK), .inRESET(inRESET),
    .iM0_REQ(iM0_REQ), .oM0_LOCK(oM0_LOCK), .iM0_ORDER(iM0_ORDER), .iM0_MASK(iM0_MASK),
    .iM0_RW(iM0_RW), .iM0_ADDR(iM0_ADDR), .iM0_DATA(iM0_DATA), .oM0_VALID(oM0_VALID),
    .iM0_BUSY(iM0_BUSY), .oM0_DATA(oM0_DATA),
    .iM1_REQ(iM1_REQ), .oM1_LOCK(oM1_LOCK), .iM1_ORDER(iM1_ORDER), .iM1_MASK(iM1_MASK),
    .iM1_RW(iM1_RW), .iM1_ADDR(iM1_ADDR), .iM1_DATA(iM1_DATA), .oM1_VALID(oM1_VALID),
    .iM1_BUSY(iM1_BUSY), .oM1_DATA(oM1_DATA),
    .oMEMORY_REQ(oMEMORY_REQ), .oMEMORY_ORDER(oMEMORY_ORDER), .oMEMORY_MASK(oMEMORY_MASK),
    .oMEMORY_RW(oMEMORY_RW), .oMEMORY_ADDR(oMEMORY_ADDR), .oMEMORY_DATA(oMEMORY_DATA),
    .iMEMORY_LOCK(iMEMORY_LOCK), .iMEMORY_VALID(iMEMORY_VALID), .iMEMORY_DATA(iMEMORY_DATA),
    .oMEMORY_BUSY(oMEMORY_BUSY), .oERR(oERR)
  );

  always #5 iCLOCK = ~iCLOCK;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checkCount++;
    if (actual !== expected)
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    else
      passCount++;
  endtask

  task automatic nextCycle();
    @(posedge iCLOCK);
    #1;
  endtask

  // Write data is derived from the address so stage contents can be predicted.
  task automatic applyStimulus(input logic m0Req, input logic m0Rw, input logic [31:0] m0Addr,
                               input logic m1Req, input logic m1Rw, input logic [31:0] m1Addr);
    iM0_REQ = m0Req; iM0_RW = m0Rw; iM0_ADDR = m0Addr; iM0_DATA = m0Addr ^ 32'hFFFF_0000;
    iM0_ORDER = 2'b10; iM0_MASK = 4'hF;
    iM1_REQ = m1Req; iM1_RW = m1Rw; iM1_ADDR = m1Addr; iM1_DATA = m1Addr ^ 32'h5555_0000;
    iM1_ORDER = 2'b01; iM1_MASK = 4'h3;
    #2;
  endtask

  initial begin
    logic        exp0;
    logic        expId;
    logic [31:0] prevAddr;
    logic [63:0] retData;
    prevAddr = '0;
    inRESET = 1'b0; iMEMORY_LOCK = 1'b0; iMEMORY_VALID = 1'b0; iMEMORY_DATA = '0;
    iM0_BUSY = 1'b0; iM1_BUSY = 1'b0;
    #2;
    applyStimulus(1, 0, 32'h100, 1, 0, 32'h104);
    checkOutput("rst m0 lock", oM0_LOCK, 1);
    checkOutput("rst m1 lock", oM1_LOCK, 1);
    checkOutput("rst mem req", oMEMORY_REQ, 0);
    checkOutput("rst mem addr", oMEMORY_ADDR, 0);
    checkOutput("rst err", oERR, 0);
    checkOutput("rst mem busy", oMEMORY_BUSY, 0);

    // Single read from M0 on an idle memory.
    nextCycle();
    inRESET = 1'b1;
    applyStimulus(1, 0, 32'h100, 0, 0, 0);
    checkOutput("single m0 lock", oM0_LOCK, 0);
    checkOutput("single m1 lock", oM1_LOCK, 1);
    checkOutput("single req early", oMEMORY_REQ, 0);
    nextCycle();
    iM0_BUSY = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("single req", oMEMORY_REQ, 1);
    checkOutput("single addr", oMEMORY_ADDR, 32'h100);
    checkOutput("single rw", oMEMORY_RW, 0);
    checkOutput("single busy", oMEMORY_BUSY, 1);
    nextCycle();
    iMEMORY_VALID = 1'b1; iMEMORY_DATA = 64'h11;
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("single ret valid", oM0_VALID, 1);
    checkOutput("single ret data", oM0_DATA, 64'h11);
    checkOutput("single ret m1", oM1_VALID, 0);
    checkOutput("single drained", oMEMORY_REQ, 0);
    nextCycle();
    iMEMORY_VALID = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("single empty busy", oMEMORY_BUSY, 0);
    iM0_BUSY = 1'b0;

    // Both requesters read every cycle until the tag FIFO fills.
    nextCycle();
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1, 0, 32'h200, 1, 0, 32'h300);
      if (i < 4) begin
        exp0 = RR ? (i % 2 == 0) : 1'b1;
        checkOutput($sformatf("both m0 lock %0d", i), oM0_LOCK, !exp0);
        checkOutput($sformatf("both m1 lock %0d", i), oM1_LOCK, exp0);
      end else begin
        checkOutput("both full m0", oM0_LOCK, 1);
        checkOutput("both full m1", oM1_LOCK, 1);
      end
      if (i > 0) checkOutput($sformatf("both addr %0d", i), oMEMORY_ADDR, prevAddr);
      if (i < 4) prevAddr = exp0 ? 32'h200 : 32'h300;
      nextCycle();
    end
    for (int i = 0; i < 4; i++) begin
      retData = 64'hA0 + 64'(i);
      iMEMORY_VALID = 1'b1; iMEMORY_DATA = retData;
      applyStimulus(0, 0, 0, 0, 0, 0);
      expId = RR ? i[0] : 1'b0;
      checkOutput($sformatf("both ret m0v %0d", i), oM0_VALID, !expId);
      checkOutput($sformatf("both ret m1v %0d", i), oM1_VALID, expId);
      checkOutput($sformatf("both ret m0d %0d", i), oM0_DATA, expId ? 64'h0 : retData);
      checkOutput($sformatf("both ret m1d %0d", i), oM1_DATA, expId ? retData : 64'h0);
      nextCycle();
    end
    iMEMORY_VALID = 1'b0;

    // Four reads M0,M1,M1,M0 fill the FIFO; a fifth waits for a pop.
    nextCycle();
    applyStimulus(1, 0, 32'h700, 0, 0, 0);
    checkOutput("fill m0 a", oM0_LOCK, 0);
    nextCycle();
    applyStimulus(0, 0, 0, 1, 0, 32'h710);
    checkOutput("fill m1 b", oM1_LOCK, 0);
    nextCycle();
    applyStimulus(0, 0, 0, 1, 0, 32'h714);
    checkOutput("fill m1 c", oM1_LOCK, 0);
    nextCycle();
    applyStimulus(1, 0, 32'h718, 0, 0, 0);
    checkOutput("fill m0 d", oM0_LOCK, 0);
    nextCycle();
    applyStimulus(1, 0, 32'h71C, 0, 0, 0);
    checkOutput("fill full lock", oM0_LOCK, 1);
    nextCycle();
    iMEMORY_VALID = 1'b1; iMEMORY_DATA = 64'hA;
    applyStimulus(1, 0, 32'h71C, 0, 0, 0);
    checkOutput("fill pop no relief", oM0_LOCK, 1);
    checkOutput("ret A m0v", oM0_VALID, 1);
    checkOutput("ret A data", oM0_DATA, 64'hA);
    checkOutput("ret A m1v", oM1_VALID, 0);
    nextCycle();
    iMEMORY_DATA = 64'hB;
    applyStimulus(1, 0, 32'h71C, 0, 0, 0);
    checkOutput("fill fifth grant", oM0_LOCK, 0);
    checkOutput("ret B m1v", oM1_VALID, 1);
    checkOutput("ret B data", oM1_DATA, 64'hB);
    checkOutput("ret B m0d", oM0_DATA, 64'h0);
    nextCycle();
    iMEMORY_DATA = 64'hC;
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("ret C m1v", oM1_VALID, 1);
    checkOutput("ret C data", oM1_DATA, 64'hC);
    nextCycle();
    iMEMORY_DATA = 64'hD;
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("ret D m0v", oM0_VALID, 1);
    checkOutput("ret D data", oM0_DATA, 64'hD);
    checkOutput("ret D m1v", oM1_VALID, 0);
    nextCycle();
    iMEMORY_DATA = 64'hE;
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("ret E m0v", oM0_VALID, 1);
    checkOutput("ret E data", oM0_DATA, 64'hE);
    nextCycle();
    iMEMORY_VALID = 1'b0; iM0_BUSY = 1'b1; iM1_BUSY = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("fill empty busy", oMEMORY_BUSY, 0);
    checkOutput("fill no err", oERR, 0);
    iM0_BUSY = 1'b0; iM1_BUSY = 1'b0;

    // Memory locked for five cycles while the stage holds a write.
    nextCycle();
    iMEMORY_LOCK = 1'b1;
    applyStimulus(1, 1, 32'h400, 0, 0, 0);
    checkOutput("hold accept", oM0_LOCK, 0);
    for (int k = 0; k < 5; k++) begin
      nextCycle();
      applyStimulus(1, 1, 32'h410, 1, 1, 32'h500);
      checkOutput($sformatf("hold req %0d", k), oMEMORY_REQ, 1);
      checkOutput($sformatf("hold addr %0d", k), oMEMORY_ADDR, 32'h400);
      checkOutput($sformatf("hold data %0d", k), oMEMORY_DATA, 32'hFFFF_0400);
      checkOutput($sformatf("hold m0 lock %0d", k), oM0_LOCK, 1);
      checkOutput($sformatf("hold m1 lock %0d", k), oM1_LOCK, 1);
    end
    checkOutput("hold rw", oMEMORY_RW, 1);
    checkOutput("hold order", oMEMORY_ORDER, 2'b10);
    checkOutput("hold mask", oMEMORY_MASK, 4'hF);
    nextCycle();
    iMEMORY_LOCK = 1'b0;
    applyStimulus(1, 1, 32'h410, 1, 1, 32'h500);
    checkOutput("issue addr", oMEMORY_ADDR, 32'h400);
    checkOutput("issue m0 grant", oM0_LOCK, 0);
    checkOutput("issue m1 lock", oM1_LOCK, 1);
    nextCycle();
    applyStimulus(0, 0, 0, 1, 1, 32'h500);
    checkOutput("next addr m0", oMEMORY_ADDR, 32'h410);
    checkOutput("next m1 grant", oM1_LOCK, 0);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("m1 write addr", oMEMORY_ADDR, 32'h500);
    checkOutput("m1 write order", oMEMORY_ORDER, 2'b01);
    checkOutput("m1 write data", oMEMORY_DATA, 32'h5555_0500);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("stage idle", oMEMORY_REQ, 0);

    // Head tag belongs to M1: back-pressure follows M1 busy only.
    nextCycle();
    applyStimulus(0, 0, 0, 1, 0, 32'h800);
    checkOutput("head m1 grant", oM1_LOCK, 0);
    nextCycle();
    iM1_BUSY = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("head m1 busy", oMEMORY_BUSY, 1);
    iM1_BUSY = 1'b0; iM0_BUSY = 1'b1;
    #1;
    checkOutput("head m0 busy ignored", oMEMORY_BUSY, 0);
    nextCycle();
    iM0_BUSY = 1'b0; iMEMORY_VALID = 1'b1; iMEMORY_DATA = 64'h55;
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("head ret m1v", oM1_VALID, 1);
    checkOutput("head ret data", oM1_DATA, 64'h55);
    nextCycle();
    iMEMORY_DATA = 64'h66;
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("stray m0v", oM0_VALID, 0);
    checkOutput("stray m1v", oM1_VALID, 0);
    checkOutput("stray m1d", oM1_DATA, 64'h0);
    checkOutput("stray err pending", oERR, 0);
    nextCycle();
    iMEMORY_VALID = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("stray err", oERR, 1);

    // Reset mid-transfer with a held request and two tags outstanding.
    nextCycle();
    applyStimulus(1, 0, 32'h900, 0, 0, 0);
    checkOutput("mid m0 grant", oM0_LOCK, 0);
    nextCycle();
    applyStimulus(0, 0, 0, 1, 0, 32'h910);
    checkOutput("mid m1 grant", oM1_LOCK, 0);
    nextCycle();
    iMEMORY_LOCK = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("mid held req", oMEMORY_REQ, 1);
    checkOutput("mid held addr", oMEMORY_ADDR, 32'h910);
    applyStimulus(1, 0, 32'h920, 0, 0, 0);
    checkOutput("mid blocked", oM0_LOCK, 1);
    inRESET = 1'b0;
    #1;
    checkOutput("mid rst req", oMEMORY_REQ, 0);
    checkOutput("mid rst addr", oMEMORY_ADDR, 0);
    checkOutput("mid rst err", oERR, 0);
    checkOutput("mid rst lock", oM0_LOCK, 1);
    nextCycle();
    inRESET = 1'b1; iMEMORY_LOCK = 1'b0; iM0_BUSY = 1'b1; iM1_BUSY = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("post rst empty", oMEMORY_BUSY, 0);
    iMEMORY_VALID = 1'b1; iMEMORY_DATA = 64'h77;
    #1;
    checkOutput("post rst m0v", oM0_VALID, 0);
    checkOutput("post rst m1v", oM1_VALID, 0);
    nextCycle();
    iMEMORY_VALID = 1'b0; iM0_BUSY = 1'b0; iM1_BUSY = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("post rst err", oERR, 1);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/memory_bus_arbiter.md
MEMORY_BUS_ARBITER -- requirements
Module: memory_bus_arbiter

Interface
REQ-001 Parameter P_TAG_DEPTH, default 4, SHALL set the outstanding-read tag FIFO depth (power of two, 2..16).
REQ-002 Parameter P_TAG_DEPTH_N, default 2, SHALL equal log2(P_TAG_DEPTH).
REQ-003 iCLOCK  in  1  Core clock, all logic posedge.
REQ-004 inRESET  in  1  Asynchronous active-low reset.
REQ-005 iM0_REQ / iM1_REQ  in  1  Requester x transfer request, held until accepted.
REQ-006 oM0_LOCK / oM1_LOCK  out  1  Requester x not accepted this cycle.
REQ-007 iM0_ORDER / iM1_ORDER  in  2  00 byte, 01 2-byte, 10 word, 11 none.
REQ-008 iM0_MASK / iM1_MASK  in  4  Byte mask.
REQ-009 iM0_RW / iM1_RW  in  1  1 write, 0 read.
REQ-010 iM0_ADDR / iM1_ADDR  in  32  Address.
REQ-011 iM0_DATA / iM1_DATA  in  32  Write data.
REQ-012 oM0_VALID / oM1_VALID  out  1  Read data valid to requester x.
REQ-013 iM0_BUSY / iM1_BUSY  in  1  Requester x cannot take read data.
REQ-014 oM0_DATA / oM1_DATA  out  64  Read data to requester x.
REQ-015 oMEMORY_REQ, oMEMORY_ORDER[2], oMEMORY_MASK[4], oMEMORY_RW, oMEMORY_ADDR[32], oMEMORY_DATA[32]  out  Memory request stage.
REQ-016 iMEMORY_LOCK  in  1  Memory cannot accept request.
REQ-017 iMEMORY_VALID  in  1 / iMEMORY_DATA  in  64  Memory read return; oMEMORY_BUSY  out  1  back-pressure to memory.
REQ-018 oERR  out  1  Sticky: iMEMORY_VALID received with tag FIFO empty.

Function
REQ-019 A registered output stage SHALL drive all oMEMORY_* request fields; a request accepted in cycle N SHALL appear on oMEMORY_REQ in cycle N+1.
REQ-020 Stage SHALL hold fields unchanged while oMEMORY_REQ=1 and iMEMORY_LOCK=1; it drains on any cycle with oMEMORY_REQ=1 and iMEMORY_LOCK=0.
REQ-021 Acceptance allowed in a cycle only if stage empty or draining, and, for a read, tag FIFO not full (a same-cycle pop does not relieve full).
REQ-022 At most one requester SHALL be accepted per cycle; oMx_LOCK=0 only for the accepted requester, 1 for every other (including idle) requester.
REQ-023 Arbitration when both request: per REQ-035.
REQ-024 Each accepted read SHALL push the requester ID into the tag FIFO on acceptance; writes SHALL NOT push.
REQ-025 On iMEMORY_VALID=1 the FIFO head SHALL be popped and, combinationally, oMx_VALID=1 and oMx_DATA=iMEMORY_DATA for x = head ID; the other requester's VALID=0.
REQ-026 oMEMORY_BUSY SHALL equal iMx_BUSY of head ID when FIFO non-empty, else 0.
REQ-027 iMEMORY_VALID with FIFO empty SHALL be dropped (no oMx_VALID) and set oERR until reset.
REQ-028 Simultaneous push and pop on non-full FIFO SHALL keep count unchanged; pointers wrap modulo P_TAG_DEPTH.
REQ-029 oMx_DATA SHALL be 64'h0 whenever oMx_VALID=0.

Reset
REQ-030 inRESET=0 SHALL asynchronously clear: oMEMORY_REQ=0, all oMEMORY_* fields 0, tag FIFO empty, round-robin pointer to M0, oERR=0.
REQ-031 Reset mid-transfer SHALL discard the held request and all outstanding tags; returns after reset fall under REQ-027.
REQ-032 During reset oM0_LOCK=oM1_LOCK=1, oMx_VALID=0, oMEMORY_BUSY=0.

Configuration
REQ-033 Macro MEMORY_BUS_ARBITER_RR_EN SHALL select the arbitration policy.
REQ-034 Without it: fixed priority, M0 always wins.
REQ-035 With it: round-robin; pointer names the preferred requester, flips to the other ID after each grant made while both requested; single requester granted regardless of pointer.

Verification
REQ-036 M0 read addr 32'h0000_0100 only, memory idle -> oM0_LOCK=0 same cycle, oMEMORY_REQ=1 addr 0x100 RW=0 next cycle, FIFO count 1.
REQ-037 Both read every cycle, RR_EN defined -> grants alternate M0,M1,M0,M1; undefined -> M0 every cycle, oM1_LOCK=1 throughout.
REQ-038 iMEMORY_LOCK=1 for 5 cycles with request held -> oMEMORY_* stable 5 cycles, both oMx_LOCK=1, issue on cycle 6.
REQ-039 4 reads (M0,M1,M1,M0) outstanding, 5th read -> LOCK=1 until pop; returns 0xA..0xD route to M0,M1,M1,M0 in order.
REQ-040 Head=M1, iM1_BUSY=1 -> oMEMORY_BUSY=1; stray iMEMORY_VALID with empty FIFO -> oERR=1, no oMx_VALID.
REQ-041 inRESET=0 while stage held and 2 tags outstanding -> oMEMORY_REQ=0 immediately, FIFO empty after release.
